// File: rtl/core_sequencer_if.sv
// Control bundle between the core sequencer and the decoder, memories and datapath.
// The master modport is the sequencer's view; slave is the surrounding core/testbench.
interface core_sequencer_if;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  modport master (
    input  opcode, rd, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src, wb_sel,
           halted, trap_cause, instret
  );

  modport slave (
    output opcode, rd, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src, wb_sel,
           halted, trap_cause, instret
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory-wait timeouts, a sticky TRAP state and a retired-instruction counter.
module core_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  core_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [8:0] TIMEOUT_C = 9'(MEM_TIMEOUT);

  function automatic logic legal_opcode(input logic [6:0] op);
    case (op)
      OP_ALU, OP_IMM, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_opcode = 1'b1;
      default:                           legal_opcode = 1'b0;
    endcase
  endfunction

  state_t      state_r, next_state_s;
  logic [7:0]  wait_cnt_r;
  logic [31:0] instret_r;
  logic [1:0]  trap_cause_r, trap_cause_s;
  logic        timeout_s, retire_s;
  logic        imem_req_s, ir_we_s, dmem_req_s, dmem_we_s, rf_we_s, pc_we_s;
  logic [1:0]  pc_src_s, wb_sel_s;

  // Next-state and Moore/Mealy control decode from current state and opcode.
  always_comb begin
    next_state_s = state_r;
    trap_cause_s = 2'd0;
    retire_s     = 1'b0;
    imem_req_s   = 1'b0;
    ir_we_s      = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    rf_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    pc_src_s     = 2'd0;
    wb_sel_s     = 2'd0;
    // The wait that would bring the counter to MEM_TIMEOUT is the last one allowed.
    timeout_s    = (({1'b0, wait_cnt_r} + 9'd1) == TIMEOUT_C);
    case (state_r)
      FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ready) begin
          ir_we_s      = 1'b1;
          next_state_s = DECODE;
        end else if (timeout_s) begin
          next_state_s = TRAP;
          trap_cause_s = 2'd2;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        if (legal_opcode(bus.opcode)) begin
          next_state_s = EXECUTE;
        end else begin
          next_state_s = TRAP;
          trap_cause_s = 2'd1;
        end
      end
      EXECUTE: begin
        if (bus.opcode == OP_BR) begin
          pc_we_s      = 1'b1;
          pc_src_s     = bus.branch_taken ? 2'd1 : 2'd0;
          retire_s     = 1'b1;
          next_state_s = FETCH;
        end else if ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)) begin
          next_state_s = MEMORY;
        end else begin
          next_state_s = WRITEBACK;
        end
      end
      MEMORY: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (bus.opcode == OP_STORE);
        if (bus.dmem_ready) begin
          if (bus.opcode == OP_STORE) begin
            pc_we_s      = 1'b1;
            retire_s     = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = WRITEBACK;
          end
        end else if (timeout_s) begin
          next_state_s = TRAP;
          trap_cause_s = 2'd3;
        end else begin
          next_state_s = MEMORY;
        end
      end
      WRITEBACK: begin
        rf_we_s      = (bus.rd != 5'd0);
        pc_we_s      = 1'b1;
        retire_s     = 1'b1;
        next_state_s = FETCH;
        case (bus.opcode)
          OP_JAL:  begin pc_src_s = 2'd1; wb_sel_s = 2'd2; end
          OP_JALR: begin pc_src_s = 2'd2; wb_sel_s = 2'd2; end
          OP_LOAD: begin pc_src_s = 2'd0; wb_sel_s = 2'd1; end
          default: begin pc_src_s = 2'd0; wb_sel_s = 2'd0; end
        endcase
      end
      TRAP: begin
        next_state_s = TRAP;
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // State, wait counter, trap cause and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH;
      wait_cnt_r   <= 8'd0;
      instret_r    <= 32'd0;
      trap_cause_r <= 2'd0;
    end else begin
      state_r <= next_state_s;
      // Counting only while parked in a waiting state; any transition restarts it.
      if ((next_state_s == state_r) && ((state_r == FETCH) || (state_r == MEMORY))) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
      if (retire_s) begin
        instret_r <= instret_r + 32'd1;
      end
      if ((next_state_s == TRAP) && (state_r != TRAP)) begin
        trap_cause_r <= trap_cause_s;
      end
    end
  end

  assign bus.imem_req   = imem_req_s;
  assign bus.ir_we      = ir_we_s;
  assign bus.dmem_req   = dmem_req_s;
  assign bus.dmem_we    = dmem_we_s;
  assign bus.rf_we      = rf_we_s;
  assign bus.pc_we      = pc_we_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.wb_sel     = wb_sel_s;
  assign bus.halted     = (state_r == TRAP);
  assign bus.trap_cause = trap_cause_r;
  assign bus.instret    = instret_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-instruction expectations are queued when
// the instruction is driven and compared against what the sequencer retires.
module tb_core_sequencer;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  typedef struct {
    logic [1:0]  pc_src;
    logic [1:0]  wb_sel;
    int          rf_cnt;
    logic        dmem_we;
    int          dcycles;
    int          lat;
    logic [31:0] instret;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  core_sequencer_if bus();

  core_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rec_t        exp_q[$];
  rec_t        obs_q[$];
  logic [2:0]  cyc_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_instret = 32'd0;

  task automatic drive_idle();
    bus.opcode       = 7'd0;
    bus.rd           = 5'd0;
    bus.branch_taken = 1'b0;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    model_instret = 32'd0;
  endtask

  // Drives one instruction with imem/dmem ready after iw/dw wait cycles; queues expected
  // and observed retire records. Starts and ends at a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [4:0] r, input logic taken,
                           input int iw, input int dw);
    rec_t e, o;
    int cyc, fw, dwc;
    bit done, is_br, is_ld, is_st, is_mem;
    is_br  = (op == OP_BR);
    is_ld  = (op == OP_LOAD);
    is_st  = (op == OP_STORE);
    is_mem = is_ld || is_st;
    e.pc_src  = is_br ? (taken ? 2'd1 : 2'd0) : (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
    e.wb_sel  = is_ld ? 2'd1 : ((op == OP_JAL) || (op == OP_JALR)) ? 2'd2 : 2'd0;
    e.rf_cnt  = (is_br || is_st || (r == 5'd0)) ? 0 : 1;
    e.dmem_we = is_st;
    e.dcycles = is_mem ? dw + 1 : 0;
    e.lat     = (iw + 1) + 2 + (is_mem ? dw + 1 : 0) + ((is_br || is_st) ? 0 : 1);
    model_instret = model_instret + 32'd1;
    e.instret = model_instret;
    exp_q.push_back(e);

    o.pc_src = 2'd0; o.wb_sel = 2'd0; o.rf_cnt = 0; o.dmem_we = 1'b0;
    o.dcycles = 0; o.lat = -1; o.instret = 32'd0;
    cyc = 0; fw = 0; dwc = 0; done = 1'b0;
    bus.opcode = op; bus.rd = r; bus.branch_taken = taken;
    while (!done && (cyc < 64)) begin
      bus.imem_ready = bus.imem_req && (fw == iw);
      bus.dmem_ready = bus.dmem_req && (dwc == dw);
      #1;
      cyc++;
      if (bus.imem_req) fw++;
      if (bus.dmem_req) begin dwc++; o.dcycles++; end
      if (bus.dmem_we) o.dmem_we = 1'b1;
      if (bus.rf_we) o.rf_cnt++;
      if (bus.pc_we) begin
        o.pc_src = bus.pc_src;
        o.wb_sel = bus.wb_sel;
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    o.lat = done ? cyc : -1;
    o.instret = bus.instret;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    // Move off FETCH with a non-zero counter, then drop rst_n between clock edges.
    run_instr(OP_ALU, 5'd5, 1'b0, 0, 0);
    exp_q.delete(); obs_q.delete();
    bus.opcode = OP_ALU; bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_imem_req: got %b want 1", bus.imem_req); end
    n_cmp++; if (bus.instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0h want 0", bus.instret); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    n_cmp++; if (bus.trap_cause !== 2'd0) begin n_fail++; $display("FAIL reset_trap_cause: got %0d want 0", bus.trap_cause); end
    @(negedge clk);
    rst_n = 1'b1;
    model_instret = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] e, o;
    do_reset();
    bus.opcode = OP_ALU; bus.rd = 5'd5; bus.imem_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc_q.push_back({(c % 4) == 1, (c % 4) == 0, (c % 4) == 0});
      #1;
      o = {bus.ir_we, bus.rf_we, bus.pc_we};
      e = cyc_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL b2b_cycle%0d ir/rf/pc_we: got %b want %b", c, o, e); end
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    n_cmp++; if (bus.instret !== 32'd3) begin n_fail++; $display("FAIL b2b_instret: got %0d want 3", bus.instret); end
    model_instret = 32'd3;
  endtask

  task automatic test_instr_mix();
    rec_t e, o;
    int k;
    do_reset();
    run_instr(OP_ALU,   5'd5,  1'b0, 0, 0);
    run_instr(OP_IMM,   5'd0,  1'b0, 0, 0);
    run_instr(OP_LUI,   5'd7,  1'b0, 2, 0);
    run_instr(OP_AUIPC, 5'd1,  1'b0, 0, 0);
    run_instr(OP_JAL,   5'd0,  1'b0, 0, 0);
    run_instr(OP_JALR,  5'd3,  1'b0, 0, 0);
    run_instr(OP_BR,    5'd6,  1'b1, 0, 0);
    run_instr(OP_BR,    5'd6,  1'b0, 0, 0);
    run_instr(OP_STORE, 5'd2,  1'b0, 0, 0);
    run_instr(OP_LOAD,  5'd4,  1'b0, 0, 0);
    run_instr(OP_LOAD,  5'd9,  1'b0, 0, 3);
    run_instr(OP_STORE, 5'd2,  1'b0, 0, 3);
    run_instr(OP_ALU,   5'd8,  1'b0, 3, 0);
    k = 0;
    while ((exp_q.size() > 0) && (obs_q.size() > 0)) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL mix%0d latency: got %0d want %0d", k, o.lat, e.lat); end
      n_cmp++; if (o.pc_src !== e.pc_src) begin n_fail++; $display("FAIL mix%0d pc_src: got %0d want %0d", k, o.pc_src, e.pc_src); end
      n_cmp++; if (o.wb_sel !== e.wb_sel) begin n_fail++; $display("FAIL mix%0d wb_sel: got %0d want %0d", k, o.wb_sel, e.wb_sel); end
      n_cmp++; if (o.rf_cnt !== e.rf_cnt) begin n_fail++; $display("FAIL mix%0d rf_we_cycles: got %0d want %0d", k, o.rf_cnt, e.rf_cnt); end
      n_cmp++; if (o.dmem_we !== e.dmem_we) begin n_fail++; $display("FAIL mix%0d dmem_we: got %b want %b", k, o.dmem_we, e.dmem_we); end
      n_cmp++; if (o.dcycles !== e.dcycles) begin n_fail++; $display("FAIL mix%0d dmem_req_cycles: got %0d want %0d", k, o.dcycles, e.dcycles); end
      n_cmp++; if (o.instret !== e.instret) begin n_fail++; $display("FAIL mix%0d instret: got %0d want %0d", k, o.instret, e.instret); end
      k++;
    end
    n_cmp++; if (k !== 13) begin n_fail++; $display("FAIL mix_count: got %0d want 13", k); end
  endtask

  task automatic test_illegal_trap();
    do_reset();
    run_instr(OP_ALU, 5'd5, 1'b0, 0, 0);
    void'(exp_q.pop_front()); void'(obs_q.pop_front());
    bus.opcode = OP_BAD; bus.imem_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL illegal_decode_halted: got %b want 0", bus.halted); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL illegal_halted: got %b want 1", bus.halted); end
    n_cmp++; if (bus.trap_cause !== 2'd1) begin n_fail++; $display("FAIL illegal_cause: got %0d want 1", bus.trap_cause); end
    bus.opcode = OP_ALU; bus.dmem_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if ({bus.imem_req, bus.ir_we, bus.dmem_req, bus.rf_we, bus.pc_we} !== 5'd0) begin n_fail++; $display("FAIL trap_strobes: got %b want 00000", {bus.imem_req, bus.ir_we, bus.dmem_req, bus.rf_we, bus.pc_we}); end
    n_cmp++; if (bus.instret !== 32'd1) begin n_fail++; $display("FAIL trap_instret_frozen: got %0d want 1", bus.instret); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL trap_sticky: got %b want 1", bus.halted); end
    do_reset();
    #1;
    n_cmp++; if ({bus.halted, bus.trap_cause} !== 3'd0) begin n_fail++; $display("FAIL trap_cleared: got %b want 000", {bus.halted, bus.trap_cause}); end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      #1;
      n_cmp++; if (bus.halted !== (c == 5)) begin n_fail++; $display("FAIL fetch_to_cycle%0d halted: got %b want %b", c, bus.halted, (c == 5)); end
      @(negedge clk);
    end
    n_cmp++; if (bus.trap_cause !== 2'd2) begin n_fail++; $display("FAIL fetch_to_cause: got %0d want 2", bus.trap_cause); end
    do_reset();
    bus.opcode = OP_ALU;
    repeat (3) @(negedge clk);
    bus.imem_ready = 1'b1;
    #1;
    n_cmp++; if (bus.ir_we !== 1'b1) begin n_fail++; $display("FAIL fetch_late_ready ir_we: got %b want 1", bus.ir_we); end
    @(negedge clk);
    bus.imem_ready = 1'b0;
    #1;
    n_cmp++; if ({bus.halted, bus.imem_req} !== 2'b00) begin n_fail++; $display("FAIL fetch_late_ready decode: halted/imem_req got %b want 00", {bus.halted, bus.imem_req}); end
  endtask

  task automatic test_data_timeout();
    int dcyc, halt_at;
    do_reset();
    bus.opcode = OP_LOAD; bus.rd = 5'd3;
    dcyc = 0; halt_at = -1;
    for (int c = 1; c <= 12; c++) begin
      bus.imem_ready = (c == 1);
      #1;
      if (bus.dmem_req) dcyc++;
      if (bus.halted && (halt_at < 0)) halt_at = c;
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    n_cmp++; if (dcyc !== 4) begin n_fail++; $display("FAIL data_to_req_cycles: got %0d want 4", dcyc); end
    n_cmp++; if (halt_at !== 8) begin n_fail++; $display("FAIL data_to_halt_cycle: got %0d want 8", halt_at); end
    n_cmp++; if (bus.trap_cause !== 2'd3) begin n_fail++; $display("FAIL data_to_cause: got %0d want 3", bus.trap_cause); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    bus.opcode = OP_LOAD; bus.rd = 5'd3; bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL midmem_req: got %b want 1", bus.dmem_req); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.dmem_req, bus.imem_req} !== 2'b01) begin n_fail++; $display("FAIL midmem_abort dmem/imem_req: got %b want 01", {bus.dmem_req, bus.imem_req}); end
    @(negedge clk);
    rst_n = 1'b1;
    model_instret = 32'd0;
    @(negedge clk);
    #1;
    n_cmp++; if ({bus.imem_req, bus.instret} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL midmem_after: imem_req/instret got %b/%0d want 1/0", bus.imem_req, bus.instret); end
  endtask

  task automatic test_instret_wrap();
    rec_t e, o;
    do_reset();
    force dut.instret_r = 32'hFFFF_FFFF;
    #1 release dut.instret_r;
    model_instret = 32'hFFFF_FFFF;
    run_instr(OP_ALU, 5'd1, 1'b0, 0, 0);
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    n_cmp++; if (o.instret !== e.instret) begin n_fail++; $display("FAIL wrap_instret: got %0h want %0h", o.instret, e.instret); end
    n_cmp++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", o.lat, e.lat); end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_instr_mix();
    test_illegal_trap();
    test_fetch_timeout();
    test_data_timeout();
    test_reset_mid_mem();
    test_instret_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max wait cycles for imem_ready/dmem_ready before trap (legal range 1..255).
REQ-002 clk  input  1  single core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 opcode  input  7  opcode field from the instruction decoder.
REQ-005 rd  input  5  destination register index from the decoder.
REQ-006 branch_taken  input  1  branch comparator result, valid in EXECUTE.
REQ-007 imem_ready  input  1  instruction memory data valid this cycle.
REQ-008 dmem_ready  input  1  data memory access complete this cycle.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 ir_we  output  1  instruction register load strobe.
REQ-011 dmem_req  output  1  data memory request.
REQ-012 dmem_we  output  1  data memory write enable (stores).
REQ-013 rf_we  output  1  register file write enable.
REQ-014 pc_we  output  1  PC update strobe.
REQ-015 pc_src  output  2  next-PC select: 0=PC+4, 1=branch/JAL target, 2=JALR target.
REQ-016 wb_sel  output  2  writeback select: 0=ALU, 1=load data, 2=PC+4.
REQ-017 halted  output  1  sticky trap indicator.
REQ-018 trap_cause  output  2  0=none, 1=illegal opcode, 2=fetch timeout, 3=data timeout.
REQ-019 instret  output  32  retired-instruction counter.

Function
REQ-020 FSM states SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; all outputs other than counters and trap fields SHALL be decoded from current state and opcode, with no output registers.
REQ-021 FETCH: imem_req=1; on imem_ready, pulse ir_we and go to DECODE; otherwise remain.
REQ-022 DECODE: exactly one cycle; legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111; any other opcode -> TRAP with trap_cause=1; legal -> EXECUTE.
REQ-023 EXECUTE, branch (1100011): pc_we=1, pc_src=branch_taken?1:0, retire, -> FETCH.
REQ-024 EXECUTE, load/store -> MEMORY; all other legal opcodes -> WRITEBACK.
REQ-025 MEMORY: dmem_req=1, dmem_we=1 only for store; on dmem_ready, store -> pc_we=1, pc_src=0, retire, -> FETCH; load -> WRITEBACK.
REQ-026 WRITEBACK: rf_we=(rd!=0), pc_we=1, retire, -> FETCH; pc_src=1 for JAL, 2 for JALR, else 0; wb_sel=1 for load, 2 for JAL/JALR, else 0.
REQ-027 Wait counter (8-bit) SHALL clear on entry to FETCH/MEMORY and increment each cycle waiting without ready; when it reaches MEM_TIMEOUT without ready -> TRAP with trap_cause=2 (FETCH) or 3 (MEMORY).
REQ-028 Ready asserted in the same cycle the counter reaches MEM_TIMEOUT SHALL be honoured (ready wins, no trap).
REQ-029 TRAP: halted=1, all request/strobe outputs 0; TRAP SHALL be exited only by reset.
REQ-030 instret SHALL increment by 1 per retire (one cycle per instruction), wrap from 0xFFFFFFFF to 0, never increment in TRAP.
REQ-031 Latencies with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR 4 cycles, branch 3, store 4, load 5.

Reset
REQ-032 rst_n low SHALL immediately force state=FETCH, instret=0, wait counter=0, halted=0, trap_cause=0, independent of clk.
REQ-033 Reset asserted mid-instruction (any state, including MEMORY with dmem_req high) SHALL abort it without retire; first cycle after release is FETCH with imem_req=1.

Verification
REQ-034 Reset, imem_ready=1 constant, opcode=0110011, rd=5 -> FETCH,DECODE,EXECUTE,WRITEBACK repeating; rf_we=1 and pc_we=1 every 4th cycle; instret=3 after 12 cycles.
REQ-035 Load opcode 0000011, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WRITEBACK with wb_sel=1, instret+1.
REQ-036 Opcode 1111111 in DECODE -> TRAP next cycle, halted=1, trap_cause=1, instret frozen; only rst_n low clears.
REQ-037 MEM_TIMEOUT=4, imem_ready held 0 -> TRAP with trap_cause=2 after 4 waiting cycles; repeat with imem_ready=1 on 4th cycle -> DECODE, no trap.
REQ-038 Branch with branch_taken=1 then 0 -> pc_src=1 then 0, each 3 cycles, rf_we never asserted; JAL with rd=0 -> rf_we=0, pc_src=1, wb_sel=2.
REQ-039 Force instret=0xFFFFFFFF via backdoor, retire one instruction -> instret=0.
